dispense_sequencer: RTL and testbench

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

---
 rtl/dispense_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dispense_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_sequencer.sv
// dispense_sequencer
// Vending-slot dispense controller. A request picks one of four item slots;
// the controller checks stock, spins the slot motor until the IR drop sensor
// sees an item fall (with bounded retries and a motor-off settle gap between
// attempts), sounds a buzzer, and reports OK / SOLD_OUT / JAM with a
// one-cycle completion pulse. Per-item 4-bit stock counters are kept here
// and can be reloaded at any time by a restock pulse.

module dispense_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SETTLE_CYCLES  = 20,
  parameter int BUZZ_CYCLES    = 50,
  parameter int MAX_RETRY      = 2,
  parameter int STOCK_INIT     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_item,
  output logic        req_ready,
  input  logic        IR_Sensor,
  input  logic        restock,
  output logic        DC_motor,
  output logic [3:0]  motor_sel,
  output logic        buzzer,
  output logic        done_valid,
  output logic [1:0]  done_status,
  output logic [15:0] stock_level,
  output logic        busy
);

  // One shared phase timer serves RUN, SETTLE and BUZZ, so it is sized for
  // the longest of the three phases.
  localparam int MAX_TC = (TIMEOUT_CYCLES > SETTLE_CYCLES)
                        ? ((TIMEOUT_CYCLES > BUZZ_CYCLES) ? TIMEOUT_CYCLES : BUZZ_CYCLES)
                        : ((SETTLE_CYCLES > BUZZ_CYCLES) ? SETTLE_CYCLES : BUZZ_CYCLES);
  localparam int TW = $clog2(MAX_TC + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Terminal counts: the timer starts at zero on phase entry, so the last
  // cycle of a phase of length N is the one where the timer reads N-1.
  localparam logic [TW-1:0] RUN_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] BUZZ_LAST   = TW'(BUZZ_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);
  localparam logic [3:0]    STOCK_V     = 4'(STOCK_INIT);

  localparam logic [1:0] STAT_OK       = 2'b00;
  localparam logic [1:0] STAT_SOLD_OUT = 2'b01;
  localparam logic [1:0] STAT_JAM      = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_BUZZ   = 3'd4,
    ST_REPORT = 3'd5
  } state_e;

  // Slot index to one-hot motor select.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [1:0]      item_q, item_d;
  logic [1:0]      result_q, result_d;
  logic [1:0]      done_status_q, done_status_d;
  logic [15:0]     stock_q, stock_d;

  // IR drop-detector synchronizer and edge-detect history.
  logic            ir_s1_q, ir_s2_q, ir_prev_q;
  logic            detect_s;
  logic            dec_s;
  logic [3:0]      stock_cur_s;

  // Rising edge of the synchronized IR signal. Because the history flop
  // runs continuously, a sensor already high when RUN starts never shows
  // an edge inside RUN, so a blocked or stuck-high sensor cannot fake a drop.
  assign detect_s    = ir_s2_q & ~ir_prev_q;
  assign stock_cur_s = stock_q[{item_q, 2'b00} +: 4];

  // Synchronize the asynchronous IR sensor and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_s1_q   <= 1'b0;
      ir_s2_q   <= 1'b0;
      ir_prev_q <= 1'b0;
    end else begin
      ir_s1_q   <= IR_Sensor;
      ir_s2_q   <= ir_s1_q;
      ir_prev_q <= ir_s2_q;
    end
  end

  // FSM state and datapath registers; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      retry_q       <= '0;
      item_q        <= 2'd0;
      result_q      <= STAT_OK;
      done_status_q <= STAT_OK;
      stock_q       <= {4{STOCK_V}};
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      item_q        <= item_d;
      result_q      <= result_d;
      done_status_q <= done_status_d;
      stock_q       <= stock_d;
    end
  end

  // Next-state, timer, retry, result and stock update logic.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    item_d        = item_q;
    result_d      = result_q;
    stock_d       = stock_q;
    done_status_d = done_status_q;
    dec_s         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone accepts.
        if (req_valid) begin
          state_d = ST_CHECK;
          item_d  = req_item;
          timer_d = '0;
          retry_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CHECK: begin
        if (stock_cur_s == 4'd0) begin
          state_d  = ST_REPORT;
          result_d = STAT_SOLD_OUT;
        end else begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end

      ST_RUN: begin
        // A drop seen on the final timeout cycle still counts as success.
        if (detect_s) begin
          dec_s    = 1'b1;
          state_d  = ST_BUZZ;
          result_d = STAT_OK;
          timer_d  = '0;
        end else if (timer_q == RUN_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_SETTLE;
            timer_d = '0;
          end else begin
            state_d  = ST_BUZZ;
            result_d = STAT_JAM;
            timer_d  = '0;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_BUZZ: begin
        if (timer_q == BUZZ_LAST) begin
          state_d = ST_REPORT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        retry_d = '0;
      end
    endcase

    // CHECK already rejects empty slots; the zero guard keeps the counter
    // from wrapping even if that invariant were ever broken.
    if (dec_s && (stock_cur_s != 4'd0)) begin
      stock_d[{item_q, 2'b00} +: 4] = stock_cur_s - 4'd1;
    end else begin
      stock_d = stock_q;
    end

    // A restock on the same edge as a decrement wins.
    if (restock) begin
      stock_d = {4{STOCK_V}};
    end else begin
      stock_d = stock_d;
    end

    // The reported status changes only as REPORT is entered, so the output
    // shows the new result during the done pulse and holds it afterwards.
    if ((state_d == ST_REPORT) && (state_q != ST_REPORT)) begin
      done_status_d = result_d;
    end else begin
      done_status_d = done_status_q;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    req_ready  = 1'b0;
    DC_motor   = 1'b0;
    motor_sel  = 4'b0000;
    buzzer     = 1'b0;
    done_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
      end
      ST_RUN: begin
        DC_motor  = 1'b1;
        motor_sel = onehot4(item_q);
      end
      ST_BUZZ: begin
        buzzer = 1'b1;
      end
      ST_REPORT: begin
        done_valid = 1'b1;
      end
      ST_CHECK, ST_SETTLE: begin
        req_ready = 1'b0;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  assign busy        = ~req_ready;
  assign done_status = done_status_q;
  assign stock_level = stock_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: directed scenarios followed by randomized
// dispense transactions, each checked against a transaction-level model of
// the expected outcome (status, phase lengths, latency, stock).

module tb_dispense_sequencer;

  localparam int TO = 20;
  localparam int SE = 4;
  localparam int BZ = 3;
  localparam int MR = 1;
  localparam int SI = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_item;
  logic        req_ready;
  logic        IR_Sensor;
  logic        restock;
  logic        DC_motor;
  logic [3:0]  motor_sel;
  logic        buzzer;
  logic        done_valid;
  logic [1:0]  done_status;
  logic [15:0] stock_level;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  int stock_m[4];
  int last_status_m = 0;

  always #5 clk = ~clk;

  dispense_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .SETTLE_CYCLES  (SE),
    .BUZZ_CYCLES    (BZ),
    .MAX_RETRY      (MR),
    .STOCK_INIT     (SI)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_item    (req_item),
    .req_ready   (req_ready),
    .IR_Sensor   (IR_Sensor),
    .restock     (restock),
    .DC_motor    (DC_motor),
    .motor_sel   (motor_sel),
    .buzzer      (buzzer),
    .done_valid  (done_valid),
    .done_status (done_status),
    .stock_level (stock_level),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_stock();
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'(stock_m[i]);
    return v;
  endfunction

  task automatic model_restock();
    for (int i = 0; i < 4; i++) stock_m[i] = SI;
  endtask

  // mode: 0 = IR never rises, 1 = IR rises at motor cycle n of attempt att,
  // 2 = IR held high from before the request.
  task automatic run_txn(input int item, input int mode, input int att, input int n,
                         input bit rs_coincide);
    int  exp_status, exp_motor, exp_settle, exp_buzz, exp_k;
    bit  sold, ok, rs_hit, seen_done, motor_prev;
    int  motor_n, settle_n, buzz_n, done_k, attempt, run_c, sel_err, rdy_err;
    logic [1:0] status_seen;
    logic [3:0] exp_sel;

    exp_sel = 4'b0001 << item;
    sold = (stock_m[item] == 0);
    ok   = !sold && (mode == 1) && (n + 2 <= TO);
    rs_hit = ok && rs_coincide;
    if (sold) begin
      exp_status = 1; exp_motor = 0; exp_settle = 0; exp_buzz = 0; exp_k = 2;
    end else begin
      if (ok) begin
        exp_status = 0; exp_motor = att * TO + n + 2; exp_settle = att * SE;
      end else begin
        exp_status = 2; exp_motor = (MR + 1) * TO; exp_settle = MR * SE;
      end
      exp_buzz = BZ;
      exp_k = 1 + exp_motor + exp_settle + exp_buzz + 1;
    end

    if (mode == 2) begin
      @(negedge clk);
      IR_Sensor = 1'b1;
      repeat (3) @(negedge clk);
    end else begin
      @(negedge clk);
    end
    req_valid = 1'b1;
    req_item  = 2'(item);
    @(posedge clk);

    motor_n = 0; settle_n = 0; buzz_n = 0; done_k = 0; attempt = -1; run_c = 0;
    sel_err = 0; rdy_err = 0; seen_done = 1'b0; motor_prev = 1'b0; status_seen = 2'b00;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      restock  = 1'b0;
      req_item = 2'($urandom_range(0, 3));   // ignored while busy
      if (DC_motor) begin
        if (!motor_prev) begin
          attempt++;
          run_c = 0;
        end
        run_c++;
        motor_n++;
        if (motor_sel !== exp_sel) sel_err++;
        if (mode == 1 && attempt == att && run_c == n) IR_Sensor = 1'b1;
        if (rs_hit && attempt == att && run_c == n + 2) restock = 1'b1;
      end else begin
        if (motor_sel !== 4'b0000) sel_err++;
        if (motor_n > 0 && buzz_n == 0 && !buzzer && !done_valid) settle_n++;
      end
      if (buzzer) buzz_n++;
      if (req_ready || !busy) rdy_err++;
      motor_prev = DC_motor;
      if (done_valid) begin
        done_k = k;
        status_seen = done_status;
        seen_done = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    IR_Sensor = 1'b0;
    restock   = 1'b0;

    check_eq("done_seen", 32'(seen_done), 32'd1);
    check_eq("status", 32'(status_seen), 32'(exp_status));
    check_eq("done_latency", 32'(done_k), 32'(exp_k));
    check_eq("motor_cycles", 32'(motor_n), 32'(exp_motor));
    check_eq("settle_cycles", 32'(settle_n), 32'(exp_settle));
    check_eq("buzz_cycles", 32'(buzz_n), 32'(exp_buzz));
    check_eq("motor_sel_errs", 32'(sel_err), 32'd0);
    check_eq("busy_ready_errs", 32'(rdy_err), 32'd0);

    if (ok) begin
      if (rs_hit) model_restock();
      else stock_m[item] = stock_m[item] - 1;
    end
    last_status_m = exp_status;

    @(negedge clk);
    check_eq("idle_ready", 32'(req_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_done", 32'(done_valid), 32'd0);
    check_eq("status_hold", 32'(done_status), 32'(last_status_m));
    check_eq("stock", 32'(stock_level), 32'(model_stock()));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int r, it, md, at, nn;
    bit rc;
    bit motor_seen;

    reset = 1'b1; req_valid = 1'b0; req_item = 2'd0; IR_Sensor = 1'b0; restock = 1'b0;
    model_restock();
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_motor", 32'({DC_motor, motor_sel}), 32'd0);
    check_eq("rst_buzz_done", 32'({buzzer, done_valid, done_status}), 32'd0);
    check_eq("rst_stock", 32'(stock_level), 32'(model_stock()));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed scenarios.
    run_txn(2, 1, 0, 3, 1'b0);            // OK, detect at motor cycle 5
    run_txn(0, 1, 0, 4, 1'b0);
    run_txn(0, 1, 0, 10, 1'b0);
    run_txn(0, 1, 0, 4, 1'b0);            // sold out
    run_txn(1, 0, 0, 0, 1'b0);            // no IR -> JAM after retry
    run_txn(3, 2, 0, 0, 1'b0);            // IR stuck high -> JAM
    run_txn(1, 1, 1, 6, 1'b1);            // success on retry, restock coincides
    run_txn(2, 1, 0, TO - 2, 1'b0);       // detect on the last timeout cycle
    run_txn(3, 1, 0, TO - 1, 1'b0);       // detect lands just after RUN -> JAM

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        model_restock();
        check_eq("idle_restock", 32'(stock_level), 32'(model_stock()));
      end
      it = $urandom_range(0, 3);
      r  = $urandom_range(0, 9);
      at = $urandom_range(0, MR);
      rc = ($urandom_range(0, 3) == 0);
      if (r <= 5) begin md = 1; nn = $urandom_range(1, TO - 2); end
      else if (r <= 7) begin md = 0; nn = 0; end
      else if (r == 8) begin md = 2; nn = 0; end
      else begin md = 1; nn = $urandom_range(TO - 1, TO); end
      run_txn(it, md, at, nn, rc);
    end

    // Reset in the middle of RUN.
    @(negedge clk);
    req_valid = 1'b1;
    req_item  = 2'd3;
    @(posedge clk);
    motor_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (DC_motor) begin
        motor_seen = 1'b1;
        break;
      end
    end
    check_eq("mid_motor_on", 32'(motor_seen), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_restock();
    last_status_m = 0;
    check_eq("mid_rst_motor", 32'({DC_motor, motor_sel}), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
    check_eq("mid_rst_done", 32'(done_valid), 32'd0);
    check_eq("mid_rst_stock", 32'(stock_level), 32'(model_stock()));
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_done", 32'({done_valid, DC_motor}), 32'd0);
    end
    run_txn(3, 1, 0, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
